timer6502: RTL and testbench
============================

Name: timer6502

Overview:
- Programmable 16-bit interval timer that acts as a bus responder on the 6502 system bus, alongside the existing switch/LED/display I/O block.
- Sits in the 0x20?? I/O page at offset window 0x2030-0x2037; the top-level address decode drives cs.
- Provides the CPU with a periodic or one-shot interrupt source and drives the CPU irq input.
- Clocked by the same system clock as the CPU (50 MHz).

Parameters:
- PRESCALE_RESET, 8'd49, reset value of the PRESCALE register (1 µs tick at 50 MHz).
- RELOAD_RESET, 16'hFFFF, reset value of RELOAD.

Ports:
- clk  input  1  system clock (same as CPU clock).
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select from top-level address decode (addr[15:3] == 0x2030>>3).
- addr  input  3  register offset (cpu_addr[2:0]).
- din  input  8  write data from CPU.
- dout  output  8  read data to CPU mux.
- we  input  1  CPU write enable.
- irq  output  1  level interrupt request to CPU.

Behaviour:
- Register map (offset: name):
  - 0: CTRL R/W. bit0 EN, bit1 AUTO (periodic), bit2 IE (irq enable); bits 7:3 read 0.
  - 1: STATUS. bit0 EXP (write 1 to clear); bit1 RUN (read-only, = EN); bits 7:2 read 0.
  - 2/3: RELOAD_LO / RELOAD_HI, R/W.
  - 4: writing any value latches COUNT into SNAP (16 bits); reading returns SNAP[7:0].
  - 5: SNAP[15:8], read-only.
  - 6: PRESCALE, R/W.
  - 7: reads 0x00; writes ignored.
- Writes occur on posedge clk when cs && we. Writes with cs=0 are ignored.
- dout is combinational from addr and register state when cs=1; dout = 0x00 when cs=0. Reads have no side effects.
- Reset values:
  - CTRL=0, EXP=0, COUNT=0, SNAP=0, prescale counter PCNT=0.
  - RELOAD=RELOAD_RESET, PRESCALE=PRESCALE_RESET.
  - irq=0, dout=0.
- State: IDLE (EN=0) and RUN (EN=1).
  - IDLE→RUN on a CTRL write with din[0]=1 while EN=0. On that edge: COUNT<=RELOAD, PCNT<=0.
  - A CTRL write with EN=1 while already running updates AUTO/IE only; COUNT and PCNT are untouched.
  - A CTRL write with din[0]=0 forces IDLE immediately; COUNT holds its value.
- Tick generation in RUN:
  - PCNT increments each clk.
  - When PCNT==PRESCALE, a tick occurs and PCNT<=0. So a tick occurs every PRESCALE+1 clocks.
- On a tick:
  - If COUNT!=0: COUNT<=COUNT-1.
  - If COUNT==0: EXP<=1. If AUTO=1, COUNT<=RELOAD. If AUTO=0, EN<=0 (one-shot) and COUNT stays 0.
  - First expiry occurs exactly (RELOAD+1)*(PRESCALE+1) clocks after the enabling write edge.
- RELOAD writes during RUN take effect at the next reload only.
- PRESCALE writes take effect on the next compare. If PCNT > new PRESCALE, PCNT counts on and wraps at 8 bits (0xFF→0x00) before matching.
- RELOAD=0 with AUTO=1: expiry on every tick.
- Simultaneous events:
  - W1C of EXP in the same cycle as an expiry: set wins, EXP=1.
  - A CTRL write clearing EN in the same cycle as a tick: the write wins, and the tick has no effect on COUNT or EXP.
- irq = EXP & IE, combinational. Clearing IE deasserts irq without clearing EXP.
- Reset mid-operation returns every register to its reset value on the next edge, regardless of cs/we.

Test Plan:
- Reset, then read offsets 0-7 with cs=1 → 00,00,FF,FF,00,00,31,00. With cs=0 → dout=00.
- One-shot expiry: PRESCALE=0, RELOAD=0x0003, write CTRL=0x05 → EXP and irq rise exactly 4 clocks after the write edge. Afterwards RUN=0, COUNT=0, and irq stays high. Writing STATUS=0x01 → irq low the next cycle.
- Periodic mode: PRESCALE=1, RELOAD=0x0002, CTRL=0x07 → expiries 6 clocks apart for ≥5 periods. Changing RELOAD to 0x0000 mid-run → after the next reload, period = 2 clocks.
- Snapshot: RELOAD=0x1234, PRESCALE=0, enable, write offset 4 after 0x10 clocks → SNAP = 0x1224 ± checked exact value. SNAP stays stable while COUNT keeps decrementing.
- Collisions: a W1C landing in the expiry cycle → EXP stays 1. A CTRL=0x00 write on a tick cycle → COUNT unchanged and EXP unchanged.
- Reset asserted mid-count with AUTO=1 and irq=1 → next edge: irq=0, CTRL=0, RELOAD=FFFF, and no further expiries.

Source files
------------

// File: rtl/timer6502_if.sv
// CPU-side bus bundle for the timer: register select, write data, read data and interrupt.
interface timer6502_if;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          cs;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          we;
  logic          irq;

  // CPU / address-decode side
  modport master (output cs, addr, din, we, input dout, irq);
  // Timer side
  modport slave  (input cs, addr, din, we, output dout, irq);
endinterface

// File: rtl/timer6502.sv
// Programmable 16-bit interval timer on the 6502 I/O page: prescaled tick,
// one-shot or periodic expiry, sticky EXP flag and level interrupt.
module timer6502 #(
  parameter logic [7:0]  PRESCALE_RESET = 8'd49,
  parameter logic [15:0] RELOAD_RESET   = 16'hFFFF
) (
  input logic        clk,
  input logic        reset,
  timer6502_if.slave bus
);

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  localparam logic [AW-1:0] A_CTRL   = 3'd0;
  localparam logic [AW-1:0] A_STATUS = 3'd1;
  localparam logic [AW-1:0] A_RLD_LO = 3'd2;
  localparam logic [AW-1:0] A_RLD_HI = 3'd3;
  localparam logic [AW-1:0] A_SNAP_L = 3'd4;
  localparam logic [AW-1:0] A_SNAP_H = 3'd5;
  localparam logic [AW-1:0] A_PRESC  = 3'd6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          auto_q, ie_q, exp_q;
  logic [CW-1:0] reload_q, count_q, snap_q;
  logic [DW-1:0] prescale_q, pcnt_q;

  logic wr_en, wr_ctrl, wr_stat, wr_rlo, wr_rhi, wr_snap, wr_presc;
  logic start, stop_wr, tick, tick_eff, expire;

  // Register write strobes
  assign wr_en    = bus.cs && bus.we;
  assign wr_ctrl  = wr_en && (bus.addr == A_CTRL);
  assign wr_stat  = wr_en && (bus.addr == A_STATUS);
  assign wr_rlo   = wr_en && (bus.addr == A_RLD_LO);
  assign wr_rhi   = wr_en && (bus.addr == A_RLD_HI);
  assign wr_snap  = wr_en && (bus.addr == A_SNAP_L);
  assign wr_presc = wr_en && (bus.addr == A_PRESC);

  // A stopping CTRL write overrides a coincident tick entirely
  assign start    = wr_ctrl && bus.din[0] && (state_q == IDLE);
  assign stop_wr  = wr_ctrl && !bus.din[0];
  assign tick     = (state_q == RUN) && (pcnt_q == prescale_q);
  assign tick_eff = tick && !stop_wr;
  assign expire   = tick_eff && (count_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: CTRL writes take priority, one-shot expiry falls back to IDLE
  always_comb begin
    state_d = state_q;
    if (wr_ctrl)                state_d = bus.din[0] ? RUN : IDLE;
    else if (expire && !auto_q) state_d = IDLE;
  end

  // Configuration registers and snapshot latch
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      reload_q   <= RELOAD_RESET;
      prescale_q <= PRESCALE_RESET;
      snap_q     <= '0;
    end else begin
      if (wr_ctrl) begin
        auto_q <= bus.din[1];
        ie_q   <= bus.din[2];
      end
      if (wr_rlo)   reload_q[7:0]  <= bus.din;
      if (wr_rhi)   reload_q[15:8] <= bus.din;
      if (wr_presc) prescale_q     <= bus.din;
      if (wr_snap)  snap_q         <= count_q;
    end
  end

  // Prescaler and down-counter; RELOAD is only sampled at start and at reload
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q  <= '0;
      count_q <= '0;
    end else if (start) begin
      pcnt_q  <= '0;
      count_q <= reload_q;
    end else if ((state_q == RUN) && !stop_wr) begin
      pcnt_q <= tick ? '0 : DW'(pcnt_q + 8'd1);
      if (tick) begin
        if (count_q != '0) count_q <= CW'(count_q - 16'd1);
        else if (auto_q)   count_q <= reload_q;
      end
    end
  end

  // Sticky expiry flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) exp_q <= 1'b0;
    else       exp_q <= expire || (exp_q && !(wr_stat && bus.din[0]));
  end

  // Read mux and interrupt, combinational from register state
  always_comb begin
    bus.dout = '0;
    bus.irq  = exp_q && ie_q;
    if (bus.cs) begin
      case (bus.addr)
        A_CTRL:   bus.dout = {5'b0, ie_q, auto_q, (state_q == RUN)};
        A_STATUS: bus.dout = {6'b0, (state_q == RUN), exp_q};
        A_RLD_LO: bus.dout = reload_q[7:0];
        A_RLD_HI: bus.dout = reload_q[15:8];
        A_SNAP_L: bus.dout = snap_q[7:0];
        A_SNAP_H: bus.dout = snap_q[15:8];
        A_PRESC:  bus.dout = prescale_q;
        default:  bus.dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer6502.sv
// Self-checking bench for timer6502: expected read data and expiry edges are
// queued when stimulus is issued and compared when the DUT responds.
module tb_timer6502;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  timer6502_if bus ();

  timer6502 #(.PRESCALE_RESET(8'd49), .RELOAD_RESET(16'hFFFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge index: value seen #1 after a posedge numbers that edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  logic [7:0] rst_vals [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h31, 8'h00};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d, output int edge_n);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d;
    @(posedge clk);
    #1;
    edge_n = cyc;
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    int unused_edge;
    bus_write(a, d, unused_edge);
  endtask

  task automatic bus_read(input logic [2:0] a, input logic c, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.cs = c; bus.we = 1'b0; bus.addr = a;
    sb.push_back(32'(exp));
    #1;
    check_val(tag, 32'(bus.dout), sb.pop_front());
    bus.cs = 1'b0;
  endtask

  // Waits for irq high; the expected edge index must already be queued
  task automatic wait_irq(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.irq) begin
        at = cyc;
        break;
      end
    end
    check_val(tag, 32'(at), sb.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.cs = 1'b0; bus.we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Disable via CTRL=0 landing on a tick; prescale 3 gives ticks every 4 clocks
  task automatic col_disable(input logic [7:0] rld, input string tag);
    int e, d, n, cnt;
    logic ex;
    do_reset();
    wr(3'd6, 8'd3); wr(3'd2, rld); wr(3'd3, 8'h00);
    bus_write(3'd0, 8'h01, e);
    repeat (7) @(posedge clk);
    bus_write(3'd0, 8'h00, d);
    n = (d - e - 1) / 4;
    cnt = int'(rld);
    ex = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (cnt != 0) cnt--;
      else begin ex = 1'b1; break; end
    end
    wr(3'd4, 8'h00);
    bus_read(3'd4, 1'b1, 8'(cnt),      {tag, "_cnt_lo"});
    bus_read(3'd5, 1'b1, 8'(cnt >> 8), {tag, "_cnt_hi"});
    bus_read(3'd1, 1'b1, {7'b0, ex},   {tag, "_status"});
  endtask

  initial begin
    int e, t, s, s2, w, last, hi;
    logic [15:0] snap;

    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.din = '0;
    do_reset();

    // Reset values, then deselected reads and an ignored deselected write
    check_val("rst_irq", 32'(bus.irq), 32'd0);
    for (int i = 0; i < 8; i++) bus_read(3'(i), 1'b1, rst_vals[i], "rst_rd");
    for (int i = 0; i < 8; i++) bus_read(3'(i), 1'b0, 8'h00, "cs0_rd");
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b1; bus.addr = 3'd6; bus.din = 8'h07;
    @(negedge clk);
    bus.we = 1'b0;
    bus_read(3'd6, 1'b1, 8'h31, "cs0_wr_ignored");

    // One-shot: expiry (3+1)*(0+1) edges after enable
    wr(3'd6, 8'h00); wr(3'd2, 8'h03); wr(3'd3, 8'h00);
    bus_write(3'd0, 8'h05, e);
    sb.push_back(32'(e + 4));
    wait_irq("oneshot_exp", t);
    bus_read(3'd1, 1'b1, 8'h01, "oneshot_status");
    wr(3'd4, 8'h00);
    bus_read(3'd4, 1'b1, 8'h00, "oneshot_cnt_lo");
    bus_read(3'd5, 1'b1, 8'h00, "oneshot_cnt_hi");
    check_val("oneshot_irq_hold", 32'(bus.irq), 32'd1);
    wr(3'd1, 8'h01);
    check_val("oneshot_irq_clr", 32'(bus.irq), 32'd0);

    // Periodic: (2+1)*(1+1) = 6 clocks, then RELOAD=0 gives a 2-clock period
    do_reset();
    wr(3'd6, 8'h01); wr(3'd2, 8'h02); wr(3'd3, 8'h00);
    bus_write(3'd0, 8'h07, e);
    last = e;
    for (int k = 0; k < 5; k++) begin
      sb.push_back(32'(last + 6));
      wait_irq("periodic_6", t);
      last = t;
      wr(3'd1, 8'h01);
    end
    wr(3'd2, 8'h00);
    sb.push_back(32'(last + 6));
    wait_irq("periodic_last6", t);
    last = t;
    wr(3'd1, 8'h01);
    for (int k = 0; k < 3; k++) begin
      sb.push_back(32'(last + 2));
      wait_irq("periodic_2", t);
      last = t;
      wr(3'd1, 8'h01);
    end

    // Snapshot: SNAP holds COUNT as it stood before the snapshot edge
    do_reset();
    wr(3'd6, 8'h00); wr(3'd2, 8'h34); wr(3'd3, 8'h12);
    bus_write(3'd0, 8'h01, e);
    repeat (15) @(posedge clk);
    bus_write(3'd4, 8'h00, s);
    snap = 16'(32'h1234 - 32'(s - e - 1));
    bus_read(3'd4, 1'b1, snap[7:0],  "snap_lo");
    bus_read(3'd5, 1'b1, snap[15:8], "snap_hi");
    bus_read(3'd1, 1'b1, 8'h02, "snap_status_run");
    repeat (10) @(posedge clk);
    bus_read(3'd4, 1'b1, snap[7:0],  "snap_stable_lo");
    bus_read(3'd5, 1'b1, snap[15:8], "snap_stable_hi");
    bus_write(3'd4, 8'h00, s2);
    snap = 16'(32'h1234 - 32'(s2 - e - 1));
    bus_read(3'd4, 1'b1, snap[7:0],  "snap2_lo");
    bus_read(3'd5, 1'b1, snap[15:8], "snap2_hi");

    // W1C colliding with an expiry keeps EXP; one off the expiry clears it
    do_reset();
    wr(3'd6, 8'h00); wr(3'd2, 8'h03); wr(3'd3, 8'h00);
    bus_write(3'd0, 8'h07, e);
    sb.push_back(32'(e + 4));
    wait_irq("col_first_exp", t);
    repeat (3) @(posedge clk);
    bus_write(3'd1, 8'h01, w);
    bus_read(3'd1, 1'b1, (((w - e) % 4) == 0) ? 8'h03 : 8'h02, "col_w1c_on_exp");
    bus_write(3'd1, 8'h01, w);
    bus_read(3'd1, 1'b1, (((w - e) % 4) == 0) ? 8'h03 : 8'h02, "col_w1c_off_exp");

    // Disabling write on a tick: count and EXP untouched by that tick
    col_disable(8'd5, "col_dis_cnt");
    col_disable(8'd1, "col_dis_exp");

    // Reset mid-count with a coincident CTRL write
    do_reset();
    wr(3'd6, 8'h00); wr(3'd2, 8'h02); wr(3'd3, 8'h00);
    bus_write(3'd0, 8'h07, e);
    sb.push_back(32'(e + 3));
    wait_irq("rstmid_exp", t);
    @(negedge clk);
    reset = 1'b1; bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 3'd0; bus.din = 8'h07;
    @(posedge clk);
    #1;
    check_val("rstmid_irq", 32'(bus.irq), 32'd0);
    reset = 1'b0; bus.cs = 1'b0; bus.we = 1'b0;
    bus_read(3'd0, 1'b1, 8'h00, "rstmid_ctrl");
    bus_read(3'd2, 1'b1, 8'hFF, "rstmid_rld_lo");
    bus_read(3'd3, 1'b1, 8'hFF, "rstmid_rld_hi");
    bus_read(3'd6, 1'b1, 8'h31, "rstmid_presc");
    hi = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.irq) hi++;
    end
    check_val("rstmid_quiet", 32'(hi), 32'd0);
    bus_read(3'd1, 1'b1, 8'h00, "rstmid_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
